// File: rtl/chk_seq.sv
// Stream sink/checker for the sequence-generator protocol: regenerates the expected
// counter sequence, compares every accepted beat, counts beats/frames/errors/aborts.
module chk_seq #(
   parameter int W       = 16,
   parameter int BSY_OFF = 10,
   parameter int BSY_ON  = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] cnt_ini,
   input  logic [W-1:0] cnt_max,
   input  logic [W-1:0] cnt_inc,
   input  logic         bsy_en,
   input  logic [W-1:0] uc_d0,
   input  logic [3:0]   uc_mflags,
   output logic [1:0]   cu_sflags,
   output logic         err_pulse,
   output logic [15:0]  err_cnt,
   output logic [31:0]  beat_cnt,
   output logic [15:0]  frame_cnt,
   output logic [7:0]   abort_cnt
);

   localparam int PER = BSY_OFF + BSY_ON;
   localparam int PW  = (PER > 1) ? $clog2(PER) : 1;

   logic [PW-1:0] phase_q, phase_d;
   logic          bsy_q, bsy_d;
   logic [W-1:0]  exp_q, exp_d;
   logic          exp_first_q, exp_first_d;
   logic          bad_q, bad_d;
   logic          err_flag_q, err_flag_d;
   logic          err_pulse_q, err_pulse_d;
   logic [15:0]   err_cnt_q, err_cnt_d;
   logic [31:0]   beat_cnt_q, beat_cnt_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]    abort_cnt_q, abort_cnt_d;

   logic          f_a, f_f, f_l, f_v;
   logic          acc, beat_ok, abort_ok;
   logic [W:0]    exp_sum;
   logic          exp_last;
   logic          mismatch;
   logic          frame_done;

   assign f_a = uc_mflags[3];
   assign f_f = uc_mflags[2];
   assign f_l = uc_mflags[1];
   assign f_v = uc_mflags[0];

   assign acc      = f_v & ~bsy_q;
   assign beat_ok  = acc & ~f_a;
   assign abort_ok = acc & f_a;

   // One extra bit so a sum past cnt_max is seen as "last" instead of wrapping.
   assign exp_sum  = {1'b0, exp_q} + {1'b0, cnt_inc};
   assign exp_last = exp_sum > {1'b0, cnt_max};

   assign mismatch   = beat_ok & ((uc_d0 != exp_q) | (f_f != exp_first_q) | (f_l != exp_last));
   assign frame_done = beat_ok & exp_last & ~bad_q & ~mismatch;

   // Backpressure phase runs freely; bsy is registered from the upcoming phase.
   always_comb begin
      phase_d = phase_q + 1'b1;
      if (phase_q == PW'(PER - 1)) begin
         phase_d = '0;
      end
      bsy_d = bsy_en && (BSY_ON != 0) && (int'(phase_d) >= BSY_OFF);
   end

   always_comb begin
      exp_d       = exp_q;
      exp_first_d = exp_first_q;
      bad_d       = bad_q;
      if (abort_ok) begin
         exp_d       = cnt_ini;
         exp_first_d = 1'b1;
         bad_d       = 1'b0;
      end else if (beat_ok) begin
         if (exp_last) begin
            exp_d       = cnt_ini;
            exp_first_d = 1'b1;
            bad_d       = 1'b0;
         end else begin
            exp_d       = exp_sum[W-1:0];
            exp_first_d = 1'b0;
            bad_d       = bad_q | mismatch;
         end
      end
   end

   always_comb begin
      err_pulse_d = mismatch;
      err_flag_d  = err_flag_q | mismatch;
      err_cnt_d   = err_cnt_q;
      if (mismatch && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
      beat_cnt_d = beat_cnt_q;
      if (beat_ok) begin
         beat_cnt_d = beat_cnt_q + 32'd1;
      end
      frame_cnt_d = frame_cnt_q;
      if (frame_done) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
      abort_cnt_d = abort_cnt_q;
      if (abort_ok && (abort_cnt_q != 8'hFF)) begin
         abort_cnt_d = abort_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q     <= '0;
         bsy_q       <= 1'b0;
         exp_q       <= cnt_ini;
         exp_first_q <= 1'b1;
         bad_q       <= 1'b0;
         err_flag_q  <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
         abort_cnt_q <= '0;
      end else begin
         phase_q     <= phase_d;
         bsy_q       <= bsy_d;
         exp_q       <= exp_d;
         exp_first_q <= exp_first_d;
         bad_q       <= bad_d;
         err_flag_q  <= err_flag_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign cu_sflags = {err_flag_q, bsy_q};
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign beat_cnt  = beat_cnt_q;
   assign frame_cnt = frame_cnt_q;
   assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_chk_seq.sv
// Directed bench for chk_seq: the driver pushes per-beat expectations into a queue,
// a monitor pops them one cycle after each observed accept and compares outputs.
module tb_chk_seq;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] cnt_ini, cnt_max, cnt_inc, uc_d0;
   logic         bsy_en;
   logic [3:0]   uc_mflags;
   logic [1:0]   cu_sflags;
   logic         err_pulse;
   logic [15:0]  err_cnt, frame_cnt;
   logic [31:0]  beat_cnt;
   logic [7:0]   abort_cnt;

   always #5 clk = ~clk;

   chk_seq #(.W(W), .BSY_OFF(10), .BSY_ON(2)) dut (
      .clk(clk), .rst(rst),
      .cnt_ini(cnt_ini), .cnt_max(cnt_max), .cnt_inc(cnt_inc),
      .bsy_en(bsy_en), .uc_d0(uc_d0), .uc_mflags(uc_mflags),
      .cu_sflags(cu_sflags), .err_pulse(err_pulse), .err_cnt(err_cnt),
      .beat_cnt(beat_cnt), .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
   );

   typedef struct {
      logic        ep;
      logic [31:0] beat;
      logic [15:0] frame;
      logic [15:0] err;
      logic [7:0]  abrt;
      logic        sticky;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic        pend = 1'b0;
   logic [31:0] m_beat;
   logic [15:0] m_frame, m_err;
   logic [7:0]  m_abrt;
   logic        m_sticky;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) pend <= !rst && uc_mflags[0] && !cu_sflags[0];

   // Monitor: outputs reflect an accept one cycle later.
   always @(negedge clk) begin
      exp_t e;
      if (pend) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_accept: got accept, expected none (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            chk("err_pulse", {31'd0, err_pulse}, {31'd0, e.ep});
            chk("beat_cnt", beat_cnt, e.beat);
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, e.frame});
            chk("err_cnt", {16'd0, err_cnt}, {16'd0, e.err});
            chk("abort_cnt", {24'd0, abort_cnt}, {24'd0, e.abrt});
            chk("err_flag", {31'd0, cu_sflags[1]}, {31'd0, e.sticky});
            $display("beat checked: beat=%0d frame=%0d err=%0d abort=%0d pulse=%0b",
                     beat_cnt, frame_cnt, err_cnt, abort_cnt, err_pulse);
         end
      end else begin
         chk("idle_err_pulse", {31'd0, err_pulse}, 32'd0);
      end
   end

   // Caller is at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [W-1:0] d, input logic [3:0] fl,
                       input logic e_err, input logic e_frm);
      int waits = 0;
      uc_d0     = d;
      uc_mflags = fl;
      while (cu_sflags[0] && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (cu_sflags[0]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got bsy stuck, expected accept of %0h", d);
         uc_mflags = 4'b0000;
         @(negedge clk);
         return;
      end
      if (fl[3]) begin
         if (m_abrt != 8'hFF) m_abrt++;
      end else begin
         m_beat++;
         if (e_err) begin
            m_err++;
            m_sticky = 1'b1;
         end
         if (e_frm) m_frame++;
      end
      sb.push_back('{ep: e_err && !fl[3], beat: m_beat, frame: m_frame,
                     err: m_err, abrt: m_abrt, sticky: m_sticky});
      @(negedge clk);
      uc_mflags = 4'b0000;
   endtask

   // Clean 1..5 frame for ini=1, max=5, inc=1.
   task automatic frame5();
      for (int v = 1; v <= 5; v++) begin
         send(W'(v), {1'b0, v == 1, v == 5, 1'b1}, 1'b0, v == 5);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      uc_mflags = 4'b0000;
      @(negedge clk);
      rst      = 1'b0;
      m_beat   = '0;
      m_frame  = '0;
      m_err    = '0;
      m_abrt   = '0;
      m_sticky = 1'b0;
      chk("rst_sflags", {30'd0, cu_sflags}, 32'd0);
      chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("rst_beat_cnt", beat_cnt, 32'd0);
      chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("rst_abort_cnt", {24'd0, abort_cnt}, 32'd0);
      chk("rst_sb_empty", sb.size(), 32'd0);
   endtask

   task automatic final_chk(input string tag, input logic [31:0] b, input logic [15:0] f,
                            input logic [15:0] e, input logic [7:0] a, input logic s);
      $display("%s: beat=%0d frame=%0d err=%0d abort=%0d errflag=%0b",
               tag, beat_cnt, frame_cnt, err_cnt, abort_cnt, cu_sflags[1]);
      chk({tag, "_beat"}, beat_cnt, b);
      chk({tag, "_frame"}, {16'd0, frame_cnt}, {16'd0, f});
      chk({tag, "_err"}, {16'd0, err_cnt}, {16'd0, e});
      chk({tag, "_abort"}, {24'd0, abort_cnt}, {24'd0, a});
      chk({tag, "_errflag"}, {31'd0, cu_sflags[1]}, {31'd0, s});
   endtask

   initial begin
      int c0;
      rst       = 1'b1;
      bsy_en    = 1'b0;
      cnt_ini   = 16'd1;
      cnt_max   = 16'd5;
      cnt_inc   = 16'd1;
      uc_d0     = '0;
      uc_mflags = 4'b0000;
      @(negedge clk);

      // Three clean frames at full rate.
      do_reset();
      c0 = cyc;
      repeat (3) frame5();
      chk("t1_cycles", cyc - c0, 32'd15);
      final_chk("t1", 32'd15, 16'd3, 16'd0, 8'd0, 1'b0);

      // Value 3 of frame 2 corrupted to 7.
      do_reset();
      frame5();
      send(16'd1, 4'b0101, 1'b0, 1'b0);
      send(16'd2, 4'b0001, 1'b0, 1'b0);
      send(16'd7, 4'b0001, 1'b1, 1'b0);
      send(16'd4, 4'b0001, 1'b0, 1'b0);
      send(16'd5, 4'b0011, 1'b0, 1'b0);
      frame5();
      final_chk("t2", 32'd15, 16'd2, 16'd1, 8'd0, 1'b1);

      // Backpressure: bsy on phases 10,11 of 12.
      bsy_en = 1'b1;
      do_reset();
      for (int k = 0; k < 24; k++) begin
         chk("bsy_phase", {31'd0, cu_sflags[0]}, {31'd0, (k % 12) >= 10});
         @(negedge clk);
      end
      c0 = cyc;
      repeat (3) frame5();
      chk("t3_cycles", cyc - c0, 32'd17);
      final_chk("t3", 32'd15, 16'd3, 16'd0, 8'd0, 1'b0);
      bsy_en = 1'b0;

      // Abort mid-frame (A together with F/L: only abort applies).
      do_reset();
      send(16'd1, 4'b0101, 1'b0, 1'b0);
      send(16'd2, 4'b0001, 1'b0, 1'b0);
      send(16'd3, 4'b1111, 1'b0, 1'b0);
      frame5();
      final_chk("t4", 32'd7, 16'd1, 16'd0, 8'd1, 1'b0);

      // ini > max: single-beat frames.
      cnt_ini = 16'd6;
      do_reset();
      repeat (3) send(16'd6, 4'b0111, 1'b0, 1'b1);
      final_chk("t5a", 32'd3, 16'd3, 16'd0, 8'd0, 1'b0);

      // Top of range: 0,8000 without wrap; missing L on a last beat still wraps.
      cnt_ini = 16'd0;
      cnt_max = 16'hFFFF;
      cnt_inc = 16'h8000;
      do_reset();
      send(16'h0000, 4'b0101, 1'b0, 1'b0);
      send(16'h8000, 4'b0011, 1'b0, 1'b1);
      send(16'h0000, 4'b0101, 1'b0, 1'b0);
      send(16'h8000, 4'b0011, 1'b0, 1'b1);
      send(16'h0000, 4'b0101, 1'b0, 1'b0);
      send(16'h8000, 4'b0001, 1'b1, 1'b0);
      send(16'h0000, 4'b0101, 1'b0, 1'b0);
      send(16'h8000, 4'b0011, 1'b0, 1'b1);
      final_chk("t5b", 32'd8, 16'd3, 16'd1, 8'd0, 1'b1);

      // Reset after beat 3, then a fresh frame.
      cnt_ini = 16'd1;
      cnt_max = 16'd5;
      cnt_inc = 16'd1;
      do_reset();
      send(16'd1, 4'b0101, 1'b0, 1'b0);
      send(16'd2, 4'b0001, 1'b0, 1'b0);
      send(16'd3, 4'b0001, 1'b0, 1'b0);
      do_reset();
      frame5();
      final_chk("t6", 32'd5, 16'd1, 16'd0, 8'd0, 1'b0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
